// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - fetch/EX inputs plus training, redirect and counter outputs of the branch resolve unit
interface branch_resolve_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic             if_valid;
   logic [PC_W-1:0]  if_pc;
   logic             if_pred_taken;
   logic [PC_W-1:0]  if_pred_target;
   logic             stall;
   logic             ex_is_branch;
   logic             ex_is_jump;
   logic             ex_taken;
   logic [PC_W-1:0]  ex_target;
   logic             bp_update;
   logic             bp_taken;
   logic [PC_W-1:0]  bp_pc_ex;
   logic [PC_W-1:0]  bp_target_pc;
   logic             redirect;
   logic [PC_W-1:0]  redirect_pc;
   logic             flush;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] mispred_count;

   modport master (
      output if_valid, if_pc, if_pred_taken, if_pred_target, stall,
             ex_is_branch, ex_is_jump, ex_taken, ex_target,
      input  bp_update, bp_taken, bp_pc_ex, bp_target_pc,
             redirect, redirect_pc, flush, br_count, mispred_count
   );

   modport slave (
      input  if_valid, if_pc, if_pred_taken, if_pred_target, stall,
             ex_is_branch, ex_is_jump, ex_taken, ex_target,
      output bp_update, bp_taken, bp_pc_ex, bp_target_pc,
             redirect, redirect_pc, flush, br_count, mispred_count
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - carries predictions to EX, resolves them, trains the predictor and redirects fetch
module branch_resolve_unit #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
) (
   input logic              clk,
   input logic              rst,
   branch_resolve_if.slave  bus
);
   typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

   state_t           state, state_next;
   logic             id_v, ex_v, id_pt, ex_pt;
   logic [PC_W-1:0]  id_pc, ex_pc, id_ptgt, ex_ptgt;
   logic             active, taken, br, train, mis, mis_seq;
   logic [PC_W-1:0]  seq_pc, mis_target, redirect_pc_q;
   logic             bp_update_q, bp_taken_q;
   logic [PC_W-1:0]  bp_pc_ex_q, bp_target_pc_q;
   logic [CNT_W-1:0] br_count_q, mispred_count_q;

   assign active = (state == RUN) && !bus.stall && ex_v;
   assign taken  = bus.ex_taken | bus.ex_is_jump;
   assign br     = bus.ex_is_branch | bus.ex_is_jump;
   assign train  = active & br;
   assign seq_pc = ex_pc + PC_W'(4);

   // A predicted-taken non-branch is a BTB alias: fall through, but never train on it.
   always_comb begin
      mis_seq    = ex_pt & (!br | !taken);
      mis        = active & (mis_seq
                   | (br & !ex_pt & taken)
                   | (br & ex_pt & taken & (ex_ptgt != bus.ex_target)));
      mis_target = mis_seq ? seq_pc : bus.ex_target;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   always_comb begin
      state_next      = state;
      bus.redirect    = 1'b0;
      bus.flush       = 1'b0;
      bus.redirect_pc = '0;
      case (state)
         RUN: if (mis) state_next = RECOVER;
         RECOVER: begin
            state_next      = RUN;
            bus.redirect    = 1'b1;
            bus.flush       = 1'b1;
            bus.redirect_pc = redirect_pc_q;
         end
         default: state_next = RUN;
      endcase
   end

   // Pipeline slots; RECOVER shifts in a bubble so the wrong-path fetch is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_v    <= 1'b0;
         id_pt   <= 1'b0;
         id_pc   <= '0;
         id_ptgt <= '0;
         ex_v    <= 1'b0;
         ex_pt   <= 1'b0;
         ex_pc   <= '0;
         ex_ptgt <= '0;
      end else if (state == RECOVER) begin
         id_v    <= 1'b0;
         ex_v    <= 1'b0;
      end else if (mis) begin
         id_v    <= 1'b0;
         ex_v    <= 1'b0;
      end else if (!bus.stall) begin
         ex_v    <= id_v;
         ex_pt   <= id_pt;
         ex_pc   <= id_pc;
         ex_ptgt <= id_ptgt;
         id_v    <= bus.if_valid;
         id_pt   <= bus.if_pred_taken;
         id_pc   <= bus.if_pc;
         id_ptgt <= bus.if_pred_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bp_update_q     <= 1'b0;
         bp_taken_q      <= 1'b0;
         bp_pc_ex_q      <= '0;
         bp_target_pc_q  <= '0;
         redirect_pc_q   <= '0;
         br_count_q      <= '0;
         mispred_count_q <= '0;
      end else begin
         bp_update_q    <= train;
         bp_taken_q     <= train & taken;
         bp_pc_ex_q     <= train ? ex_pc : '0;
         bp_target_pc_q <= train ? bus.ex_target : '0;
         if (mis) redirect_pc_q <= mis_target;
         if (train && (br_count_q != {CNT_W{1'b1}}))
            br_count_q <= br_count_q + CNT_W'(1);
         if (mis && (mispred_count_q != {CNT_W{1'b1}}))
            mispred_count_q <= mispred_count_q + CNT_W'(1);
      end
   end

   assign bus.bp_update     = bp_update_q;
   assign bus.bp_taken      = bp_taken_q;
   assign bus.bp_pc_ex      = bp_pc_ex_q;
   assign bus.bp_target_pc  = bp_target_pc_q;
   assign bus.br_count      = br_count_q;
   assign bus.mispred_count = mispred_count_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and random checks of branch_resolve_unit against an in-flight queue model
module tb_branch_resolve_unit;
   localparam int PC_W  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct {
      bit          v;
      logic [31:0] pc;
      bit          pt;
      logic [31:0] ptgt;
   } slot_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   slot_t       pipe[$];
   bit          m_rec;
   int          m_br, m_mis;
   bit          e_update, e_taken, e_redirect;
   logic [31:0] e_pc, e_tgt, e_rpc;
   int          saved;

   branch_resolve_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
   branch_resolve_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      slot_t inv;
      inv = '{v: 1'b0, pc: 32'h0, pt: 1'b0, ptgt: 32'h0};
      pipe = {};
      pipe.push_back(inv);
      pipe.push_back(inv);
      m_rec = 1'b0;
      m_br  = 0;
      m_mis = 0;
   endtask

   // One clock: drive inputs, predict the cycle-N+1 outputs, then compare just after the edge.
   task automatic cyc(bit iv, logic [31:0] ipc, bit ipt, logic [31:0] iptgt, bit st,
                      bit isbr, bit isj, bit tk, logic [31:0] tgt);
      slot_t ex, inv, fetched;
      bit t, b, wrong;
      logic [31:0] dest;
      inv     = '{v: 1'b0, pc: 32'h0, pt: 1'b0, ptgt: 32'h0};
      fetched = '{v: iv, pc: ipc, pt: ipt, ptgt: iptgt};
      bus.if_valid = iv; bus.if_pc = ipc; bus.if_pred_taken = ipt; bus.if_pred_target = iptgt;
      bus.stall = st; bus.ex_is_branch = isbr; bus.ex_is_jump = isj;
      bus.ex_taken = tk; bus.ex_target = tgt;
      ex = pipe[0];
      e_update = 0; e_taken = 0; e_pc = 0; e_tgt = 0; e_redirect = 0; e_rpc = 0;
      if (m_rec) begin
         pipe = {}; pipe.push_back(inv); pipe.push_back(inv);
         m_rec = 0;
      end else if (!st && ex.v) begin
         t = tk | isj;
         b = isbr | isj;
         wrong = 0;
         dest = tgt;
         if (b) begin
            e_update = 1; e_taken = t; e_pc = ex.pc; e_tgt = tgt;
            if (m_br < CMAX) m_br++;
            if (ex.pt && !t) begin
               wrong = 1;
               dest = ex.pc + 32'd4;
            end else if (ex.pt != t) wrong = 1;
            else if (t && ex.ptgt != tgt) wrong = 1;
         end else if (ex.pt) begin
            wrong = 1;
            dest = ex.pc + 32'd4;
         end
         if (wrong) begin
            e_redirect = 1; e_rpc = dest;
            if (m_mis < CMAX) m_mis++;
            pipe = {}; pipe.push_back(inv); pipe.push_back(inv);
            m_rec = 1;
         end else begin
            void'(pipe.pop_front());
            pipe.push_back(fetched);
         end
      end else if (!st) begin
         void'(pipe.pop_front());
         pipe.push_back(fetched);
      end
      @(posedge clk);
      #1;
      check("bp_update", bus.bp_update, e_update);
      if (e_update) begin
         check("bp_taken", bus.bp_taken, e_taken);
         check("bp_pc_ex", bus.bp_pc_ex, e_pc);
         check("bp_target_pc", bus.bp_target_pc, e_tgt);
      end
      check("redirect", bus.redirect, e_redirect);
      check("flush", bus.flush, e_redirect);
      if (e_redirect) check("redirect_pc", bus.redirect_pc, e_rpc);
      check("br_count", bus.br_count, m_br);
      check("mispred_count", bus.mispred_count, m_mis);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Fetch one instruction, let it reach EX, then resolve it with the given outcome.
   task automatic resolve_one(logic [31:0] pc, bit pt, logic [31:0] ptgt,
                              bit isbr, bit isj, bit tk, logic [31:0] tgt);
      cyc(1, pc, pt, ptgt, 0, 0, 0, 0, 0);
      idle();
      cyc(0, 0, 0, 0, 0, isbr, isj, tk, tgt);
   endtask

   initial begin
      bus.if_valid = 0; bus.if_pc = 0; bus.if_pred_taken = 0; bus.if_pred_target = 0;
      bus.stall = 0; bus.ex_is_branch = 0; bus.ex_is_jump = 0; bus.ex_taken = 0; bus.ex_target = 0;
      model_reset();
      #12;
      check("rst_bp_update", bus.bp_update, 0);
      check("rst_redirect", bus.redirect, 0);
      check("rst_flush", bus.flush, 0);
      check("rst_br_count", bus.br_count, 0);
      check("rst_mispred_count", bus.mispred_count, 0);
      rst = 1'b0;
      idle();

      resolve_one(32'h100, 0, 32'h0, 1, 0, 0, 32'h140);
      check("beq_nt_update", bus.bp_update, 1);
      check("beq_nt_taken", bus.bp_taken, 0);
      check("beq_nt_redirect", bus.redirect, 0);
      idle();
      check("beq_nt_one_cycle", bus.bp_update, 0);

      resolve_one(32'h200, 1, 32'h240, 1, 0, 0, 32'h240);
      check("pt_nt_redirect_pc", bus.redirect_pc, 32'h204);
      check("pt_nt_flush", bus.flush, 1);
      check("pt_nt_mispred", bus.mispred_count, 1);
      cyc(1, 32'h240, 0, 32'h0, 1, 1, 0, 1, 32'h260);
      check("recover_one_cycle", bus.flush, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 1, 32'h260);
      check("wrong_path_no_resolve", bus.bp_update, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 1, 32'h260);
      check("wrong_path_no_resolve2", bus.bp_update, 0);

      resolve_one(32'h300, 1, 32'h400, 0, 1, 0, 32'h480);
      check("jalr_redirect_pc", bus.redirect_pc, 32'h480);
      check("jalr_taken", bus.bp_taken, 1);
      idle();

      saved = m_br;
      resolve_one(32'h500, 1, 32'h600, 0, 0, 0, 32'h0);
      check("alias_redirect_pc", bus.redirect_pc, 32'h504);
      check("alias_no_update", bus.bp_update, 0);
      check("alias_br_count", bus.br_count, saved);
      idle();

      cyc(1, 32'h700, 0, 32'h0, 0, 0, 0, 0, 0);
      idle();
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 1, 1, 0, 0, 32'h740);
         check("stall_no_update", bus.bp_update, 0);
      end
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 32'h740);
      check("stall_single_update", bus.bp_update, 1);
      idle();
      check("stall_no_double", bus.bp_update, 0);

      resolve_one(32'h800, 1, 32'h900, 1, 0, 0, 32'h900);
      check("pre_rst_flush", bus.flush, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_recover_redirect", bus.redirect, 0);
      check("rst_mid_recover_flush", bus.flush, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle();

      for (int i = 0; i < 20; i++) begin
         resolve_one(32'h1000 + 32'(i * 16), 1, 32'h2000, 0, 0, 0, 32'h0);
         idle();
      end
      check("mispred_saturate", bus.mispred_count, 32'hF);

      resolve_one(32'hFFFF_FFFC, 1, 32'h10, 1, 0, 0, 32'h10);
      check("pc_wrap_redirect_pc", bus.redirect_pc, 32'h0);
      idle();

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, b;
         a = 32'h4000 + 32'($urandom_range(0, 3) * 4);
         b = 32'h4000 + 32'($urandom_range(0, 3) * 4);
         cyc($urandom_range(0, 3) != 0, 32'h3000 + 32'(i * 4), $urandom_range(0, 2) == 0, a,
             $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
